// File: rtl/cdb_arbiter.sv
// rtl/cdb_arbiter.sv - per-source result FIFOs with round-robin selection onto the Common Data Bus
module cdb_arbiter #(
   parameter int                 NUM_SRC     = 4,
   parameter int                 DEPTH       = 2,
   parameter int                 ROB_W       = 6,
   parameter int                 DATA_W      = 32,
   parameter logic [ROB_W-1:0]   INVALID_ROB = 6'b010000,
   localparam int                SRC_W       = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1
) (
   input  logic                        clock,
   input  logic                        rst_n,
   input  logic [NUM_SRC-1:0]          src_valid,
   input  logic [NUM_SRC*ROB_W-1:0]    src_rob,
   input  logic [NUM_SRC*DATA_W-1:0]   src_data,
   output logic [NUM_SRC-1:0]          src_ready,
   input  logic                        flush,
   output logic                        cdb_enable,
   output logic [ROB_W-1:0]            cdb_robNum,
   output logic [DATA_W-1:0]           cdb_data,
   output logic [SRC_W-1:0]            grant_id
);

   localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CNT_W = $clog2(DEPTH + 1);

   logic [ROB_W-1:0]  mem_rob_q  [NUM_SRC][DEPTH];
   logic [DATA_W-1:0] mem_data_q [NUM_SRC][DEPTH];
   logic [PTR_W-1:0]  wr_ptr_q   [NUM_SRC];
   logic [PTR_W-1:0]  rd_ptr_q   [NUM_SRC];
   logic [CNT_W-1:0]  count_q    [NUM_SRC];
   logic [CNT_W-1:0]  count_d    [NUM_SRC];

   logic              cdb_enable_q, cdb_enable_d;
   logic [ROB_W-1:0]  cdb_rob_q,    cdb_rob_d;
   logic [DATA_W-1:0] cdb_data_q,   cdb_data_d;
   logic [SRC_W-1:0]  grant_id_q,   grant_id_d;
   logic [SRC_W-1:0]  rr_ptr_q,     rr_ptr_d;

   logic [NUM_SRC-1:0] push, pop;
   logic               grant, found;
   logic [SRC_W-1:0]   win, idx;

   function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
      return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
   endfunction

   // Ready looks only at the registered count, so a full FIFO never accepts on a pop cycle.
   always_comb begin
      for (int i = 0; i < NUM_SRC; i++) begin
         src_ready[i] = rst_n & (count_q[i] < CNT_W'(DEPTH));
         push[i]      = src_valid[i] & src_ready[i];
      end
   end

   // Holding off while the bus enable is high forces a low cycle between pulses.
   always_comb begin
      found = 1'b0;
      win   = '0;
      idx   = '0;
      for (int k = 0; k < NUM_SRC; k++) begin
         idx = rr_ptr_q + SRC_W'(k);
         if (!found && (count_q[idx] != '0)) begin
            found = 1'b1;
            win   = idx;
         end
      end
      grant = found & ~cdb_enable_q & ~flush;

      for (int i = 0; i < NUM_SRC; i++) begin
         pop[i]     = grant && (win == SRC_W'(i));
         count_d[i] = flush ? '0 : count_q[i] + CNT_W'(push[i]) - CNT_W'(pop[i]);
      end

      cdb_enable_d = grant;
      cdb_rob_d    = grant ? mem_rob_q[win][rd_ptr_q[win]] : INVALID_ROB;
      cdb_data_d   = grant ? mem_data_q[win][rd_ptr_q[win]] : cdb_data_q;
      grant_id_d   = grant ? win : grant_id_q;
      rr_ptr_d     = grant ? win + SRC_W'(1) : rr_ptr_q;
   end

   always_ff @(posedge clock) begin
      if (!rst_n) begin
         cdb_enable_q <= 1'b0;
         cdb_rob_q    <= INVALID_ROB;
         cdb_data_q   <= '0;
         grant_id_q   <= '0;
         rr_ptr_q     <= '0;
         for (int i = 0; i < NUM_SRC; i++) begin
            count_q[i]  <= '0;
            wr_ptr_q[i] <= '0;
            rd_ptr_q[i] <= '0;
         end
      end else begin
         cdb_enable_q <= cdb_enable_d;
         cdb_rob_q    <= cdb_rob_d;
         cdb_data_q   <= cdb_data_d;
         grant_id_q   <= grant_id_d;
         rr_ptr_q     <= rr_ptr_d;
         for (int i = 0; i < NUM_SRC; i++) begin
            count_q[i] <= count_d[i];
            if (flush) begin
               wr_ptr_q[i] <= '0;
               rd_ptr_q[i] <= '0;
            end else begin
               if (push[i]) wr_ptr_q[i] <= ptr_inc(wr_ptr_q[i]);
               if (pop[i])  rd_ptr_q[i] <= ptr_inc(rd_ptr_q[i]);
            end
         end
      end
   end

   always_ff @(posedge clock) begin
      for (int i = 0; i < NUM_SRC; i++) begin
         if (push[i] && !flush) begin
            mem_rob_q[i][wr_ptr_q[i]]  <= src_rob[i*ROB_W +: ROB_W];
            mem_data_q[i][wr_ptr_q[i]] <= src_data[i*DATA_W +: DATA_W];
         end
      end
   end

   assign cdb_enable = cdb_enable_q;
   assign cdb_robNum = cdb_rob_q;
   assign cdb_data   = cdb_data_q;
   assign grant_id   = grant_id_q;

endmodule

// File: tb/tb_cdb_arbiter.sv
// tb/tb_cdb_arbiter.sv - scoreboard bench for cdb_arbiter
module tb_cdb_arbiter;
   localparam logic [5:0] INV = 6'h10;

   logic        clock = 1'b0;
   logic        rst_n;
   logic [3:0]  src_valid;
   logic [23:0] src_rob;
   logic [127:0] src_data;
   logic [3:0]  src_ready;
   logic        flush;
   logic        cdb_enable;
   logic [5:0]  cdb_robNum;
   logic [31:0] cdb_data;
   logic [1:0]  grant_id;

   typedef struct {
      logic [5:0]  rob;
      logic [31:0] data;
      logic [1:0]  gid;
   } exp_t;

   exp_t sb[$];
   int   total = 0;
   int   bad   = 0;
   logic rst_at_edge = 1'b0;

   cdb_arbiter dut (
      .clock(clock), .rst_n(rst_n), .src_valid(src_valid), .src_rob(src_rob),
      .src_data(src_data), .src_ready(src_ready), .flush(flush),
      .cdb_enable(cdb_enable), .cdb_robNum(cdb_robNum), .cdb_data(cdb_data),
      .grant_id(grant_id)
   );

   always #5 clock = ~clock;
   always @(posedge clock) rst_at_edge = rst_n;

   task automatic tick;
      @(posedge clock);
      #1;
   endtask

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
      total++;
      if (act !== req) begin
         bad++;
         $display("FAIL %s actual=%0h required=%0h", name, act, req);
      end
   endtask

   task automatic set_src(input int i, input logic [5:0] rob, input logic [31:0] data);
      src_rob[i*6 +: 6]   = rob;
      src_data[i*32 +: 32] = data;
   endtask

   task automatic expect_bc(input logic [5:0] rob, input logic [31:0] data, input logic [1:0] gid);
      exp_t e;
      e.rob = rob; e.data = data; e.gid = gid;
      sb.push_back(e);
   endtask

   task automatic do_reset;
      rst_n = 1'b0;
      src_valid = 4'b1111;
      tick;
      tick;
      check("rst_ready", src_ready, 4'b0000);
      check("rst_enable", cdb_enable, 1'b0);
      check("rst_rob", cdb_robNum, INV);
      rst_n = 1'b1;
      src_valid = 4'b0000;
      #1;
      check("rst_release_ready", src_ready, 4'b1111);
      repeat (3) tick;
   endtask

   // Monitor: pops on every pulse; between pulses tag is invalid and data/id hold.
   initial begin : monitor
      exp_t        e;
      logic        prev_en   = 1'b0;
      logic [31:0] last_data = '0;
      logic [1:0]  last_gid  = '0;
      forever begin
         @(negedge clock);
         if (!rst_at_edge) begin
            last_data = '0;
            last_gid  = '0;
         end
         if (cdb_enable === 1'b1) begin
            check("pulse_gap", prev_en, 1'b0);
            total++;
            if (sb.size() == 0) begin
               bad++;
               $display("FAIL unexpected_bc actual rob=%0h data=%0h gid=%0d required none",
                        cdb_robNum, cdb_data, grant_id);
               last_data = cdb_data;
               last_gid  = grant_id;
            end else begin
               e = sb.pop_front();
               if ({cdb_robNum, cdb_data, grant_id} !== {e.rob, e.data, e.gid}) begin
                  bad++;
                  $display("FAIL bc actual rob=%0h data=%0h gid=%0d required rob=%0h data=%0h gid=%0d",
                           cdb_robNum, cdb_data, grant_id, e.rob, e.data, e.gid);
               end
               last_data = e.data;
               last_gid  = e.gid;
            end
         end else begin
            check("idle_bus", {cdb_robNum, cdb_data, grant_id}, {INV, last_data, last_gid});
         end
         prev_en = cdb_enable;
      end
   end

   initial begin : stim
      int   cycles;
      int   t0, t3;
      logic bp_seen;
      logic hs0, hs3;
      flush    = 1'b0;
      src_rob  = '0;
      src_data = '0;
      do_reset;

      // Single result from src1, latency 1 edge after acceptance
      set_src(1, 6'd5, 32'hDEADBEEF);
      expect_bc(6'd5, 32'hDEADBEEF, 2'd1);
      src_valid = 4'b0010;
      tick;
      src_valid = 4'b0000;
      tick;
      check("single_en_hi", cdb_enable, 1'b1);
      tick;
      check("single_en_lo", cdb_enable, 1'b0);
      repeat (3) tick;

      // A source tag equal to the invalid code is broadcast unchanged
      set_src(3, INV, 32'hCAFE0003);
      expect_bc(INV, 32'hCAFE0003, 2'd3);
      src_valid = 4'b1000;
      tick;
      src_valid = 4'b0000;
      repeat (4) tick;

      // Contention from rr_ptr=0
      do_reset;
      for (int i = 0; i < 4; i++) begin
         set_src(i, 6'(i + 1), 32'hA0 + 32'(i));
         expect_bc(6'(i + 1), 32'hA0 + 32'(i), 2'(i));
      end
      src_valid = 4'b1111;
      tick;
      src_valid = 4'b0000;
      repeat (10) tick;

      // Backpressure on src0
      bp_seen = 1'b0;
      for (int tag = 7; tag <= 11; tag++) begin
         set_src(0, 6'(tag), 32'hB0 + 32'(tag));
         src_valid = 4'b0001;
         cycles = 0;
         while (!src_ready[0] && cycles < 20) begin
            bp_seen = 1'b1;
            tick;
            cycles++;
         end
         check("bp_timeout", cycles < 20, 1'b1);
         expect_bc(6'(tag), 32'hB0 + 32'(tag), 2'd0);
         tick;
      end
      src_valid = 4'b0000;
      check("bp_seen", bp_seen, 1'b1);
      repeat (12) tick;

      // Fairness with rr wrap: src0 and src3 always offering
      do_reset;
      for (int k = 0; k < 4; k++) begin
         expect_bc(6'(20 + k), 32'hC000 + 32'(k), 2'd0);
         expect_bc(6'(40 + k), 32'hD000 + 32'(k), 2'd3);
      end
      t0 = 0; t3 = 0; cycles = 0;
      while ((t0 < 4 || t3 < 4) && cycles < 40) begin
         set_src(0, 6'(20 + t0), 32'hC000 + 32'(t0));
         set_src(3, 6'(40 + t3), 32'hD000 + 32'(t3));
         src_valid = {t3 < 4, 2'b00, t0 < 4};
         hs0 = src_valid[0] & src_ready[0];
         hs3 = src_valid[3] & src_ready[3];
         tick;
         cycles++;
         if (hs0) t0++;
         if (hs3) t3++;
      end
      src_valid = 4'b0000;
      check("fair_timeout", cycles < 40, 1'b1);
      repeat (20) tick;

      // Flush discards queued entries and same-cycle pushes
      set_src(1, 6'd60, 32'hE060);
      set_src(2, 6'd50, 32'hE050);
      expect_bc(6'd60, 32'hE060, 2'd1);
      src_valid = 4'b0110;
      tick;
      set_src(2, 6'd51, 32'hE051);
      src_valid = 4'b0100;
      tick;
      check("flush_full_ready", src_ready[2], 1'b0);
      set_src(0, 6'd54, 32'hE054);
      src_valid = 4'b0001;
      flush = 1'b1;
      tick;
      flush = 1'b0;
      src_valid = 4'b0000;
      check("flush_ready", src_ready, 4'b1111);
      repeat (4) tick;
      set_src(2, 6'd52, 32'hE052);
      expect_bc(6'd52, 32'hE052, 2'd2);
      src_valid = 4'b0100;
      tick;
      src_valid = 4'b0000;
      repeat (6) tick;

      check("sb_drain", 64'(sb.size()), 64'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
